// File: rtl/ehgu_fifo_burst_gen.sv
// Purpose : bursty write-side traffic source for the FIFO. It runs num_bursts bursts of burst_len beats,
//           separated by gap_len idle cycles, and reports status.
// Latency : the first wr_en appears one edge after the edge that samples start. All outputs are registered.
// Backpressure: hold=1 freezes the sequence and forces wr_en low on the next cycle.
//               stop=1 aborts to IDLE on the next cycle without a done pulse.
// Ports   : clk0/wrstn            clock, asynchronous active-low reset
//           start/stop/hold       sequence control
//           burst_len/gap_len/num_bursts  run configuration, latched on start
//           wr_en/wr_data         FIFO write strobe and data
//           busy/done/word_count  status: in BURST/GAP, completion pulse, beats issued (saturating)
// Build option: define EHGU_BURST_GEN_LFSR_EN to replace the incrementing data counter with a
//               maximal-length Fibonacci LFSR seeded with 1. Timing is the same in both builds.
module ehgu_fifo_burst_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8,
  parameter int NB_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk0,
  input  logic             wrstn,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [LEN_W-1:0] gap_len,
  input  logic [NB_W-1:0]  num_bursts,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [1:0] {IDLE, BURST, GAP, DONE} state_e;

  state_e           state_q;
  logic [LEN_W-1:0] blen_q, glen_q;   // latched configuration
  logic [LEN_W-1:0] beat_q;           // beats left in the current burst
  logic [LEN_W-1:0] gap_q;            // idle cycles left in the current gap
  logic [NB_W-1:0]  bursts_q;         // bursts left, including the current one
  logic [WIDTH-1:0] gen_q, gen_d;     // data generator and its next value
  logic [CNT_W-1:0] wc_q, wc_d;
  logic             wr_en_q, busy_q, done_q;
  logic [WIDTH-1:0] wr_data_q;

`ifdef EHGU_BURST_GEN_LFSR_EN
  // Tap masks (bit i set = stage i+1 tapped) for maximal-length sequences. The read-side
  // checker must use the same table.
  function automatic logic [63:0] lfsr_taps(input int w);
    case (w)
      2:       return 64'h3;
      3:       return 64'h6;
      4:       return 64'hC;
      5:       return 64'h14;
      6:       return 64'h30;
      7:       return 64'h60;
      8:       return 64'hB8;
      9:       return 64'h110;
      10:      return 64'h240;
      11:      return 64'h500;
      12:      return 64'h829;
      13:      return 64'h100D;
      14:      return 64'h2015;
      15:      return 64'h6000;
      16:      return 64'hD008;
      24:      return 64'hE10000;
      32:      return 64'h80200003;
      default: return 64'h0;
    endcase
  endfunction

  localparam logic [63:0]      TAPS     = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] GEN_SEED = WIDTH'(1);

  assign gen_d = {gen_q[WIDTH-2:0], ^(gen_q & TAPS[WIDTH-1:0])};
`else
  localparam logic [WIDTH-1:0] GEN_SEED = '0;

  assign gen_d = gen_q + WIDTH'(1);
`endif

  // word_count sticks at all-ones instead of wrapping.
  assign wc_d = (&wc_q) ? wc_q : wc_q + CNT_W'(1);

  always_ff @(posedge clk0 or negedge wrstn) begin
    if (!wrstn) begin
      state_q   <= IDLE;
      blen_q    <= '0;
      glen_q    <= '0;
      beat_q    <= '0;
      gap_q     <= '0;
      bursts_q  <= '0;
      gen_q     <= GEN_SEED;
      wc_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // start beats a simultaneous stop here: stop is not looked at in IDLE.
          if (start) begin
            blen_q   <= burst_len;
            glen_q   <= gap_len;
            beat_q   <= burst_len;
            bursts_q <= num_bursts;
            gen_q    <= GEN_SEED;
            wc_q     <= '0;
            if (burst_len == '0 || num_bursts == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= BURST;
              busy_q  <= 1'b1;
            end
          end
        end
        BURST: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (!hold) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= gen_q;
            gen_q     <= gen_d;
            wc_q      <= wc_d;
            if (beat_q == LEN_W'(1)) begin
              if (bursts_q == NB_W'(1)) begin
                // busy stays high while the final beat is on the bus; DONE clears it.
                state_q <= DONE;
              end else begin
                bursts_q <= bursts_q - NB_W'(1);
                beat_q   <= blen_q;
                if (glen_q != '0) begin
                  gap_q   <= glen_q;
                  state_q <= GAP;
                end
              end
            end else begin
              beat_q <= beat_q - LEN_W'(1);
            end
          end
        end
        GAP: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (!hold) begin
            if (gap_q == LEN_W'(1)) begin
              state_q <= BURST;
            end else begin
              gap_q <= gap_q - LEN_W'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= !stop;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_ehgu_fifo_burst_gen.sv
// Purpose : self-checking bench for ehgu_fifo_burst_gen. A slot-queue model derived from the run
//           configuration predicts every output cycle by cycle.
// Latency : outputs are sampled on the falling edge, half a cycle after the edge that produced them.
// Backpressure: hold and stop are driven from directed knobs and random draws. The model applies them:
//               a held edge consumes no slot, and a stop edge ends the run.
module tb_ehgu_fifo_burst_gen;

  localparam int WIDTH = 8;
  localparam int LEN_W = 8;
  localparam int NB_W  = 8;
  localparam int CNT_W = 16;

  logic             clk0 = 1'b0;
  logic             wrstn;
  logic             start, stop, hold;
  logic [LEN_W-1:0] burst_len, gap_len;
  logic [NB_W-1:0]  num_bursts;
  logic             wr_en, busy, done;
  logic [WIDTH-1:0] wr_data;
  logic [CNT_W-1:0] word_count;

  ehgu_fifo_burst_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W), .NB_W(NB_W), .CNT_W(CNT_W)) dut (
    .clk0       (clk0),
    .wrstn      (wrstn),
    .start      (start),
    .stop       (stop),
    .hold       (hold),
    .burst_len  (burst_len),
    .gap_len    (gap_len),
    .num_bursts (num_bursts),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  always #5 clk0 = ~clk0;

  int n_checks = 0;
  int n_fails  = 0;

  // Model state.
  logic [WIDTH-1:0] m_gen;
  logic [WIDTH-1:0] m_last_data;
  int               m_beats;
  logic [WIDTH-1:0] seen[$];

  // Knobs for the next run (-1 disables).
  int k_hold_pct  = 0;
  int k_hold_at   = -1;
  int k_hold_len  = 0;
  int k_stop_at   = -1;
  int k_rst_at    = -1;
  int k_start_stp = 0;
  int k_poke      = 0;

`ifdef EHGU_BURST_GEN_LFSR_EN
  localparam logic [WIDTH-1:0] SEED = 8'h01;
  function automatic logic [WIDTH-1:0] gen_next(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] taps;
    taps = 8'hB8;
    return {g[WIDTH-2:0], ^(g & taps)};
  endfunction
`else
  localparam logic [WIDTH-1:0] SEED = 8'h00;
  function automatic logic [WIDTH-1:0] gen_next(input logic [WIDTH-1:0] g);
    return WIDTH'((int'(g) + 1) % (1 << WIDTH));
  endfunction
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic ew, input logic eb, input logic ed);
    check({tag, ".wr_en"},      64'(wr_en),      64'(ew));
    check({tag, ".wr_data"},    64'(wr_data),    64'(m_last_data));
    check({tag, ".busy"},       64'(busy),       64'(eb));
    check({tag, ".done"},       64'(done),       64'(ed));
    check({tag, ".word_count"}, 64'(word_count), 64'(m_beats));
  endtask

  // One run. The model expands the configuration into a list of slots (1 = beat, 0 = gap cycle),
  // followed by an implicit done slot.
  task automatic run(input string name, input int bl, input int gl, input int nb);
    int   slots[$];
    int   budget, cyc, hold_left, s;
    bit   fin, hold_used;
    logic ew, eb, ed;
    if (bl > 0) begin
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < bl; i++) slots.push_back(1);
        if (b < nb - 1) for (int i = 0; i < gl; i++) slots.push_back(0);
      end
    end
    seen.delete();
    @(negedge clk0);
    burst_len  = LEN_W'(bl);
    gap_len    = LEN_W'(gl);
    num_bursts = NB_W'(nb);
    start      = 1'b1;
    stop       = 1'(k_start_stp);
    hold       = 1'b0;
    m_gen      = SEED;
    m_beats    = 0;
    @(negedge clk0);
    start = 1'b0;
    stop  = 1'b0;
    check_outputs({name, ".start"}, 1'b0, 1'(slots.size() > 0), 1'b0);
    budget    = (slots.size() + 2) * 4 + k_hold_len + 20;
    cyc       = 0;
    fin       = 0;
    hold_used = 0;
    hold_left = 0;
    while (!fin && cyc < budget) begin
      cyc++;
      if (k_rst_at >= 0 && m_beats == k_rst_at) begin
        // Asynchronous reset between clock edges.
        #2 wrstn = 1'b0;
        #1;
        m_last_data = '0;
        m_beats     = 0;
        check_outputs({name, ".async_rst"}, 1'b0, 1'b0, 1'b0);
        @(negedge clk0);
        wrstn = 1'b1;
        fin   = 1;
      end else begin
        stop = 1'(k_stop_at >= 0 && m_beats == k_stop_at);
        if (!hold_used && k_hold_at >= 0 && m_beats == k_hold_at) begin
          hold_left = k_hold_len;
          hold_used = 1;
        end
        if (hold_left > 0) begin
          hold = 1'b1;
          hold_left--;
        end else begin
          hold = 1'($urandom_range(99) < k_hold_pct);
        end
        // Config and start changes while the run is active must be ignored.
        start = 1'($urandom_range(99) < k_poke);
        if (k_poke > 0) begin
          burst_len  = LEN_W'($urandom);
          gap_len    = LEN_W'($urandom);
          num_bursts = NB_W'($urandom);
        end
        if (stop) begin
          ew = 0; eb = 0; ed = 0; fin = 1;
        end else if (slots.size() == 0) begin
          ew = 0; eb = 0; ed = 1; fin = 1;
        end else if (hold) begin
          ew = 0; eb = 1; ed = 0;
        end else begin
          s  = slots.pop_front();
          ew = 1'(s);
          if (s == 1) begin
            m_last_data = m_gen;
            seen.push_back(m_gen);
            m_gen = gen_next(m_gen);
            m_beats++;
          end
          eb = 1'(slots.size() > 0 || s == 1);
          ed = 0;
        end
        @(negedge clk0);
        check_outputs({name, ".cyc"}, ew, eb, ed);
      end
    end
    if (!fin) check({name, ".timeout"}, 64'(0), 64'(1));
    start = 1'b0;
    stop  = 1'b0;
    hold  = 1'b0;
    @(negedge clk0);
    check_outputs({name, ".idle"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int distinct;
    bit uniq[int];
    wrstn       = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    hold        = 1'b0;
    burst_len   = '0;
    gap_len     = '0;
    num_bursts  = '0;
    m_last_data = '0;
    m_beats     = 0;
    #1;
    check_outputs("reset", 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk0);
    wrstn = 1'b1;
    @(negedge clk0);
    check_outputs("post_reset", 1'b0, 1'b0, 1'b0);

    run("gapped", 4, 2, 3);
    check("gapped.total", 64'(seen.size()), 64'(12));
    run("b2b", 3, 0, 2);
    run("zero_len", 0, 3, 5);
    run("zero_nb", 5, 1, 0);

    k_hold_at = 3; k_hold_len = 3;
    run("hold", 8, 1, 1);
    check("hold.no_skip", 64'(seen[3]), 64'(gen_next(gen_next(gen_next(SEED)))));
    k_hold_at = -1; k_hold_len = 0;

    k_stop_at = 5;
    run("stop", 10, 2, 2);
    k_stop_at = -1;

    k_rst_at = 4;
    run("rst_mid", 10, 0, 2);
    k_rst_at = -1;
    run("after_rst", 2, 1, 2);

    k_start_stp = 1;
    run("start_stop", 2, 1, 2);
    k_start_stp = 0;

    run("wrap", 200, 0, 2);
    check("wrap.total", 64'(seen.size()), 64'(400));
`ifdef EHGU_BURST_GEN_LFSR_EN
    check("wrap.first", 64'(seen[0]), 64'(1));
    for (int i = 0; i < 255; i++) uniq[int'(seen[i])] = 1'b1;
    distinct = uniq.num();
    check("wrap.distinct", 64'(distinct), 64'(255));
`else
    check("wrap.b256", 64'(seen[255]), 64'(255));
    check("wrap.b257", 64'(seen[256]), 64'(0));
    distinct = 0;
`endif

    k_hold_pct = 20;
    k_poke     = 20;
    for (int r = 0; r < 12; r++) begin
      k_stop_at = ($urandom_range(3) == 0) ? int'($urandom_range(10)) : -1;
      run("rand", int'($urandom_range(6)), int'($urandom_range(3)), int'($urandom_range(4)));
    end
    k_hold_pct = 0;
    k_poke     = 0;
    k_stop_at  = -1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
